// File: rtl/gemm_loop_controller_if.sv
// Handshake/bus bundle between the GEMM loop controller and its surroundings.
//   start_i, M/K/N_size_i          : run request and matrix sizes (into the controller)
//   sram_a/b_addr_o                : A/B read addresses (one-cycle read latency SRAMs)
//   sram_c_addr_o, sram_c_we_o     : C write port control
//   mac_valid_o/clr_o/last_o       : accumulator strobes
//   busy_o, done_o                 : run status
interface gemm_loop_controller_if #(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 8
) ();
  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     sram_c_we_o;
  logic                     mac_valid_o;
  logic                     mac_clr_o;
  logic                     mac_last_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output start_i, M_size_i, K_size_i, N_size_i,
    input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
           mac_valid_o, mac_clr_o, mac_last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, M_size_i, K_size_i, N_size_i,
    output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
           mac_valid_o, mac_clr_o, mac_last_o, busy_o, done_o
  );
endinterface

// File: rtl/gemm_loop_controller.sv
// GEMM loop controller: latches M/K/N on start, walks the m/n/k loop nest
// (k innermost), issues A/B SRAM read addresses, drives the MAC strobes one
// cycle later (SRAM read latency) and writes each finished C element one
// cycle after its last MAC. All outputs are registered.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : gemm_loop_controller_if slave modport (start/sizes in, SRAM
//            addresses, MAC strobes, busy/done out)
module gemm_loop_controller #(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  gemm_loop_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
  logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
  // Row bases m*K (A), k*N (B), m*N (C), accumulated with adders.
  logic [AddrWidth-1:0]     a_row_q, b_row_q, c_row_q;
  logic [AddrWidth-1:0]     a_addr_q, b_addr_q, c_addr_q, c_pipe_q;
  logic                     valid_q, clr_q, last_q, we_q, busy_q, done_q, drain_q;

  logic                     k_last, n_last, m_last;
  logic [SizeAddrWidth-1:0] m_d, n_d, k_d;
  logic [AddrWidth-1:0]     a_row_d, b_row_d, c_row_d;
  logic [AddrWidth-1:0]     a_addr_d, b_addr_d;
  logic                     size_zero;

  always_comb begin
    k_last    = ((k_q + 1'b1) == k_size_q);
    n_last    = ((n_q + 1'b1) == n_size_q);
    m_last    = ((m_q + 1'b1) == m_size_q);
    size_zero = (bus.M_size_i == '0) || (bus.K_size_i == '0) || (bus.N_size_i == '0);
    m_d       = m_q;
    n_d       = n_q;
    k_d       = k_q;
    a_row_d   = a_row_q;
    b_row_d   = b_row_q;
    c_row_d   = c_row_q;
    if (!k_last) begin
      k_d     = k_q + 1'b1;
      b_row_d = b_row_q + AddrWidth'(n_size_q);
    end else begin
      k_d     = '0;
      b_row_d = '0;
      if (!n_last) begin
        n_d = n_q + 1'b1;
      end else begin
        n_d     = '0;
        m_d     = m_q + 1'b1;
        a_row_d = a_row_q + AddrWidth'(k_size_q);
        c_row_d = c_row_q + AddrWidth'(n_size_q);
      end
    end
    a_addr_d = a_row_d + AddrWidth'(k_d);
    b_addr_d = b_row_d + AddrWidth'(n_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      b_row_q  <= '0;
      c_row_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_pipe_q <= '0;
      valid_q  <= 1'b0;
      clr_q    <= 1'b0;
      last_q   <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      // Read pipeline: strobes follow the issued address by one cycle, the
      // C write follows the last strobe by one more cycle. These stages run
      // freely so the final element drains through DRAIN without special cases.
      valid_q  <= (state_q == RUN);
      clr_q    <= (state_q == RUN) && (k_q == '0);
      last_q   <= (state_q == RUN) && k_last;
      c_pipe_q <= c_row_q + AddrWidth'(n_q);
      we_q     <= last_q;
      c_addr_q <= last_q ? c_pipe_q : '0;
      done_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            m_size_q <= bus.M_size_i;
            k_size_q <= bus.K_size_i;
            n_size_q <= bus.N_size_i;
            busy_q   <= 1'b1;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_row_q  <= '0;
            b_row_q  <= '0;
            c_row_q  <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            if (size_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (k_last && n_last && m_last) begin
            state_q  <= DRAIN;
            drain_q  <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
          end else begin
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            a_row_q  <= a_row_d;
            b_row_q  <= b_row_d;
            c_row_q  <= c_row_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sram_a_addr_o = a_addr_q;
  assign bus.sram_b_addr_o = b_addr_q;
  assign bus.sram_c_addr_o = c_addr_q;
  assign bus.sram_c_we_o   = we_q;
  assign bus.mac_valid_o   = valid_q;
  assign bus.mac_clr_o     = clr_q;
  assign bus.mac_last_o    = last_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

// File: tb/tb_gemm_loop_controller.sv
// Directed and random bench for gemm_loop_controller with a behavioural
// SRAM/MAC model and a golden matrix product.
module tb_gemm_loop_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gemm_loop_controller_if #(.AddrWidth(12), .SizeAddrWidth(8)) bus ();

  gemm_loop_controller #(.AddrWidth(12), .SizeAddrWidth(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM A/B with one-cycle read latency, MAC accumulator, SRAM C.
  int mem_a [0:4095];
  int mem_b [0:4095];
  int mem_c [0:4095];
  int rd_a, rd_b, acc;

  always @(posedge clk) begin
    if (bus.sram_c_we_o) mem_c[bus.sram_c_addr_o] = acc;
    rd_a <= mem_a[bus.sram_a_addr_o];
    rd_b <= mem_b[bus.sram_b_addr_o];
    if (bus.mac_valid_o) acc <= bus.mac_clr_o ? rd_a * rd_b : acc + rd_a * rd_b;
  end

  // Capture results of one run.
  int          done_cycle, n_done, n_we, n_valid, n_busy, first_we;
  logic [11:0] cap_a [0:63];
  logic [11:0] cap_b [0:63];
  logic [11:0] cap_c [0:63];
  logic        cap_clr  [0:63];
  logic        cap_last [0:63];
  logic        cap_we   [0:63];
  logic        cap_vld  [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'h0, bus.sram_a_addr_o, bus.sram_b_addr_o, bus.sram_c_addr_o,
            bus.sram_c_we_o, bus.mac_valid_o, bus.mac_clr_o, bus.mac_last_o,
            bus.busy_o, bus.done_o};
  endfunction

  task automatic fill_data(input int m, input int k, input int n);
    for (int i = 0; i < m * k; i++) mem_a[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < k * n; i++) mem_b[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 4096; i++) mem_c[i] = 32'h5A5A_5A5A;
  endtask

  // Start at edge 0; cycle c is observed at the negedge after edge c-1.
  task automatic run(input int m, input int k, input int n,
                     input int r1, input int r2, input int rst_c, input int limit);
    done_cycle = -1; n_done = 0; n_we = 0; n_valid = 0; n_busy = 0; first_we = -1;
    @(negedge clk);
    bus.M_size_i = 8'(m);
    bus.K_size_i = 8'(k);
    bus.N_size_i = 8'(n);
    bus.start_i  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      bus.start_i = (c == r1) || (c == r2);
      if (c == 1) begin
        bus.M_size_i = 8'd7;
        bus.K_size_i = 8'd7;
        bus.N_size_i = 8'd7;
      end
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset", all_outs(), 64'h0);
      end
      if (c == rst_c + 1) rst_n = 1'b1;
      if (bus.done_o) begin
        n_done++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (bus.sram_c_we_o) begin
        n_we++;
        if (first_we < 0) first_we = c;
      end
      if (bus.mac_valid_o) n_valid++;
      if (bus.busy_o) n_busy++;
      if (c < 64) begin
        cap_a[c]    = bus.sram_a_addr_o;
        cap_b[c]    = bus.sram_b_addr_o;
        cap_c[c]    = bus.sram_c_addr_o;
        cap_clr[c]  = bus.mac_clr_o;
        cap_last[c] = bus.mac_last_o;
        cap_we[c]   = bus.sram_c_we_o;
        cap_vld[c]  = bus.mac_valid_o;
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic check_c(input int m, input int k, input int n, input string tag);
    int sum;
    int bad;
    bad = 0;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        sum = 0;
        for (int x = 0; x < k; x++) sum += mem_a[i * k + x] * mem_b[x * n + j];
        if (mem_c[i * n + j] !== sum) begin
          if (bad == 0) check({tag, "_elem"}, 64'(mem_c[i * n + j]), 64'(sum));
          bad++;
        end
      end
    end
    check({tag, "_bad_elems"}, 64'(bad), 64'h0);
  endtask

  initial begin
    int exp_a [12];
    int exp_b [12];
    int m, k, n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start_i  = 1'b0;
    bus.M_size_i = '0;
    bus.K_size_i = '0;
    bus.N_size_i = '0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 0;
      mem_b[i] = 0;
      mem_c[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outs(), 64'h0);

    // 1x1x1, 3 * -4
    fill_data(1, 1, 1);
    mem_a[0] = 3;
    mem_b[0] = -4;
    run(1, 1, 1, -1, -1, -1, 20);
    check("t1_c0", 64'(mem_c[0]), 64'(-12));
    check("t1_done_cycle", 64'(done_cycle), 64'd4);
    check("t1_we_cycle", 64'(first_we), 64'd3);
    check("t1_we_count", 64'(n_we), 64'd1);

    // 2x3x2 address/strobe sequence
    exp_a = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    exp_b = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
    fill_data(2, 3, 2);
    run(2, 3, 2, -1, -1, -1, 40);
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t2_a_c%0d", c), 64'(cap_a[c]), 64'(exp_a[c-1]));
      check($sformatf("t2_b_c%0d", c), 64'(cap_b[c]), 64'(exp_b[c-1]));
    end
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("t2_strobes_c%0d", c),
            {60'h0, cap_vld[c], cap_clr[c], cap_last[c], cap_we[c]},
            {60'h0, (c >= 2 && c <= 13), (c == 2 || c == 5 || c == 8 || c == 11),
             (c == 4 || c == 7 || c == 10 || c == 13), (c == 5 || c == 8 || c == 11 || c == 14)});
    end
    check("t2_c_addr_c5", 64'(cap_c[5]), 64'd0);
    check("t2_c_addr_c8", 64'(cap_c[8]), 64'd1);
    check("t2_c_addr_c11", 64'(cap_c[11]), 64'd2);
    check("t2_c_addr_c14", 64'(cap_c[14]), 64'd3);
    check("t2_ab_idle_c16", {40'h0, cap_a[16], cap_b[16]}, 64'h0);
    check("t2_done_cycle", 64'(done_cycle), 64'd15);
    check("t2_busy_cycles", 64'(n_busy), 64'd15);
    check_c(2, 3, 2, "t2");

    // Zero K
    run(4, 0, 4, -1, -1, -1, 20);
    check("t3_done_cycle", 64'(done_cycle), 64'd1);
    check("t3_we_count", 64'(n_we), 64'd0);
    check("t3_valid_count", 64'(n_valid), 64'd0);
    check("t3_busy_cycles", 64'(n_busy), 64'd1);

    // start re-asserted while busy
    fill_data(2, 2, 2);
    run(2, 2, 2, 3, 9, -1, 40);
    check("t4_done_cycle", 64'(done_cycle), 64'd11);
    check("t4_done_count", 64'(n_done), 64'd1);
    check("t4_we_count", 64'(n_we), 64'd4);
    check_c(2, 2, 2, "t4");
    @(negedge clk);
    check("t4_idle_after", 64'(bus.busy_o), 64'd0);

    // Reset mid-run, then a fresh run
    fill_data(4, 4, 4);
    run(4, 4, 4, -1, -1, 20, 90);
    check("t5_done_count", 64'(n_done), 64'd0);
    check("t5_busy_after", 64'(bus.busy_o), 64'd0);
    fill_data(2, 2, 2);
    run(2, 2, 2, -1, -1, -1, 40);
    check("t5_restart_done", 64'(done_cycle), 64'd11);
    check_c(2, 2, 2, "t5");

    // Random sizes and int8 data
    for (int t = 0; t < 10; t++) begin
      m = 32; k = 32; n = 32;
      for (int tries = 0; tries < 100; tries++) begin
        m = int'($urandom_range(1, 32));
        k = int'($urandom_range(1, 32));
        n = int'($urandom_range(1, 32));
        if (m * k * n <= 6000) break;
      end
      if (m * k * n > 6000) k = 1;
      fill_data(m, k, n);
      run(m, k, n, -1, -1, -1, m * k * n + 10);
      check($sformatf("rnd%0d_done_cycle", t), 64'(done_cycle), 64'(m * n * k + 3));
      check($sformatf("rnd%0d_we_count", t), 64'(n_we), 64'(m * n));
      check_c(m, k, n, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
